px_pattern_check: RTL and testbench

PX_PATTERN_CHECK -- requirements
Module: px_pattern_check

---
 rtl/px_pattern_check.sv | 143 ++++++++++++++
 tb/tb_px_pattern_check.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/px_pattern_check.sv
// Training-pattern checker: waits for alignment to settle, counts consecutive matches
// against TRAIN_PATTERN and flags lock. Define PX_PATTERN_CHECK_ERR_CNT_EN to build the error counter.
module px_pattern_check #(
  parameter int DATA_WIDTH    = 12,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  px_clk,
  input  logic                  px_rst_n,
  input  logic [DATA_WIDTH-1:0] TRAIN_PATTERN,
  input  logic [15:0]           CHECK_PATTERN_NUM,
  input  logic [DATA_WIDTH-1:0] px_data,
  input  logic                  px_valid,
  input  logic                  bit_reverse,
  input  logic [7:0]            slip_num,
  input  logic [7:0]            delay_num,
  output logic                  pattern_locked,
  output logic [15:0]           match_cnt_out,
  output logic [15:0]           err_cnt_out
);

  typedef enum logic [1:0] {ST_SETTLE, ST_CHECK, ST_LOCKED} state_t;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = d[DATA_WIDTH-1-i];
    bit_rev = r;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] match_q, match_d;
  logic        locked_q, locked_d;
  logic [16:0] align_q, align_d;
  logic        align_chg, word_hit;
  logic        err_inc, err_clr;
  logic [15:0] target;

  assign align_d   = {bit_reverse, slip_num, delay_num};
  assign align_chg = (align_d != align_q);
  assign target    = (CHECK_PATTERN_NUM == 16'd0) ? 16'd1 : CHECK_PATTERN_NUM;
  assign word_hit  = ((bit_reverse ? bit_rev(px_data) : px_data) == TRAIN_PATTERN);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    locked_d = locked_q;
    err_inc  = 1'b0;
    err_clr  = 1'b0;
    // An alignment change overrides everything, including a valid word this cycle.
    if (align_chg) begin
      state_d  = ST_SETTLE;
      settle_d = SETTLE_INIT;
      match_d  = 16'd0;
      locked_d = 1'b0;
      err_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (settle_q <= 8'd1) begin
            state_d  = ST_CHECK;
            settle_d = 8'd0;
          end else begin
            settle_d = settle_q - 8'd1;
          end
        end
        ST_CHECK: begin
          if (px_valid) begin
            if (word_hit) begin
              match_d = sat_inc(match_q);
              if (match_d >= target) begin
                state_d  = ST_LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              match_d = 16'd0;
              err_inc = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (px_valid) begin
            if (word_hit) begin
              match_d = sat_inc(match_q);
            end else begin
              state_d  = ST_CHECK;
              locked_d = 1'b0;
              match_d  = 16'd0;
              err_inc  = 1'b1;
            end
          end
        end
        default: state_d = ST_SETTLE;
      endcase
    end
  end

  always_ff @(posedge px_clk) begin
    align_q <= align_d;
    if (!px_rst_n) begin
      state_q  <= ST_SETTLE;
      settle_q <= SETTLE_INIT;
      match_q  <= 16'd0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      locked_q <= locked_d;
    end
  end

`ifdef PX_PATTERN_CHECK_ERR_CNT_EN
  logic [15:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (err_clr)      err_d = 16'd0;
    else if (err_inc) err_d = sat_inc(err_q);
  end

  always_ff @(posedge px_clk) begin
    if (!px_rst_n) err_q <= 16'd0;
    else           err_q <= err_d;
  end

  assign err_cnt_out = err_q;
`else
  logic unused_err;
  assign unused_err  = err_inc ^ err_clr;
  assign err_cnt_out = 16'h0;
`endif

  assign pattern_locked = locked_q;
  assign match_cnt_out  = match_q;

endmodule

// File: tb/tb_px_pattern_check.sv
// Directed bench for px_pattern_check: settle timing, lock/unlock, alignment-change priority,
// bit-reverse compare and error-counter saturation.
module tb_px_pattern_check;

`ifdef PX_PATTERN_CHECK_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        px_clk = 1'b0;
  logic        px_rst_n;
  logic [11:0] TRAIN_PATTERN;
  logic [15:0] CHECK_PATTERN_NUM;
  logic [11:0] px_data;
  logic        px_valid;
  logic        bit_reverse;
  logic [7:0]  slip_num;
  logic [7:0]  delay_num;
  logic        pattern_locked;
  logic [15:0] match_cnt_out;
  logic [15:0] err_cnt_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 px_clk = ~px_clk;

  px_pattern_check #(.DATA_WIDTH(12), .SETTLE_CYCLES(16)) dut (
    .px_clk            (px_clk),
    .px_rst_n          (px_rst_n),
    .TRAIN_PATTERN     (TRAIN_PATTERN),
    .CHECK_PATTERN_NUM (CHECK_PATTERN_NUM),
    .px_data           (px_data),
    .px_valid          (px_valid),
    .bit_reverse       (bit_reverse),
    .slip_num          (slip_num),
    .delay_num         (delay_num),
    .pattern_locked    (pattern_locked),
    .match_cnt_out     (match_cnt_out),
    .err_cnt_out       (err_cnt_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [11:0] d);
    px_valid = v;
    px_data  = d;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic l, input logic [15:0] m, input logic [15:0] e);
    chk({tag, ".locked"}, {31'd0, pattern_locked}, {31'd0, l});
    chk({tag, ".match"}, {16'd0, match_cnt_out}, {16'd0, m});
    chk({tag, ".err"}, {16'd0, err_cnt_out}, {16'd0, ERR_EN ? e : 16'd0});
  endtask

  // Alignment-change edge followed by 16 settle edges with a matching valid word every cycle
  // (target 1): outputs stay clear for 16 edges, lock appears on the 17th.
  task automatic settle_then_lock(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk({tag, ".settle_lock"}, {31'd0, pattern_locked}, 32'd0);
      chk({tag, ".settle_match"}, {16'd0, match_cnt_out}, 32'd0);
    end
    tick();
    chk_out({tag, ".lock"}, 1'b1, 16'd1, 16'd0);
  endtask

  initial begin
    px_rst_n          = 1'b0;
    TRAIN_PATTERN     = 12'hA5C;
    CHECK_PATTERN_NUM = 16'd1;
    px_data           = 12'hA5C;
    px_valid          = 1'b1;
    bit_reverse       = 1'b0;
    slip_num          = 8'd0;
    delay_num         = 8'd3;
    tick();
    tick();
    chk_out("reset", 1'b0, 16'd0, 16'd0);

    // Settle timing after reset release: first compare happens on the 17th edge.
    px_rst_n = 1'b1;
    settle_then_lock("release");

    // Reset while locked aborts immediately.
    px_rst_n = 1'b0;
    tick();
    chk_out("rst_mid_lock", 1'b0, 16'd0, 16'd0);
    CHECK_PATTERN_NUM = 16'd8;
    px_valid = 1'b0;
    px_rst_n = 1'b1;
    for (int k = 0; k < 16; k++) tick();

    send(1'b1, 12'hA5C);
    send(1'b1, 12'hA5C);
    chk_out("two_match", 1'b0, 16'd2, 16'd0);
    send(1'b1, 12'h123);
    chk_out("mismatch_check", 1'b0, 16'd0, 16'd1);
    for (int i = 1; i <= 4; i++) send(1'b1, 12'hA5C);
    chk_out("four_match", 1'b0, 16'd4, 16'd1);
    send(1'b0, 12'h000);
    chk_out("invalid_hold", 1'b0, 16'd4, 16'd1);
    for (int i = 5; i <= 7; i++) send(1'b1, 12'hA5C);
    chk_out("seven_match", 1'b0, 16'd7, 16'd1);
    send(1'b1, 12'hA5C);
    chk_out("lock_at_8", 1'b1, 16'd8, 16'd1);
    send(1'b1, 12'hA5C);
    send(1'b1, 12'hA5C);
    chk_out("locked_count", 1'b1, 16'd10, 16'd1);

    send(1'b1, 12'h000);
    chk_out("unlock", 1'b0, 16'd0, 16'd2);

    // New pattern and target take effect on the next compare.
    TRAIN_PATTERN     = 12'h3C3;
    CHECK_PATTERN_NUM = 16'd2;
    send(1'b1, 12'hA5C);
    chk_out("new_train_miss", 1'b0, 16'd0, 16'd3);
    send(1'b1, 12'h3C3);
    chk_out("new_train_one", 1'b0, 16'd1, 16'd3);
    send(1'b1, 12'h3C3);
    chk_out("new_target_lock", 1'b1, 16'd2, 16'd3);

    // Alignment change with a matching word in the same cycle: change wins.
    CHECK_PATTERN_NUM = 16'd1;
    delay_num = 8'd4;
    send(1'b1, 12'h3C3);
    chk_out("align_chg", 1'b0, 16'd0, 16'd0);
    settle_then_lock("delay_chg");

    // Bit-reversed compare, target 0 behaves as 1.
    TRAIN_PATTERN     = 12'h001;
    CHECK_PATTERN_NUM = 16'd0;
    bit_reverse       = 1'b1;
    send(1'b1, 12'h800);
    chk_out("brev_chg", 1'b0, 16'd0, 16'd0);
    settle_then_lock("brev");

    // Error-counter saturation.
    bit_reverse = 1'b0;
    send(1'b0, 12'h000);
    for (int k = 0; k < 16; k++) tick();
    px_valid = 1'b1;
    px_data  = 12'h000;
    for (int k = 0; k < 70000; k++) tick();
    chk_out("err_sat", 1'b0, 16'd0, 16'hFFFF);
    px_rst_n = 1'b0;
    tick();
    chk_out("err_rst", 1'b0, 16'd0, 16'd0);
    px_rst_n = 1'b1;
    px_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
